fp_divider_seq: RTL

//  Parametrised signed fixed-point sequential divider, next generation of the GRU/FP

---
 rtl/fp_divider_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fp_divider_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_divider_seq
// Description : Signed fixed-point radix-2 restoring divider, one quotient bit
//               per clock, with saturation, overflow, divide-by-zero flags and
//               a signed remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_divider_seq #(
    parameter int A_W    = 22,
    parameter int B_W    = 8,
    parameter int FRAC_W = 10,
    parameter int Q_W    = 16
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start_sig,
    input  logic [A_W-1:0]        a,
    input  logic [B_W-1:0]        b,
    output logic                  busy,
    output logic                  done_sig,
    output logic [Q_W-1:0]        q,
    output logic [B_W:0]          r,
    output logic                  ovf,
    output logic                  div_zero
);

    localparam int NW = A_W + FRAC_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [Q_W-1:0] C_Q_MAX    = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic [Q_W-1:0] C_Q_MIN    = {1'b1, {(Q_W-1){1'b0}}};
    localparam logic [NW-1:0]  C_POS_LIM  = NW'(C_Q_MAX);
    localparam logic [NW-1:0]  C_NEG_MAG  = NW'(C_Q_MIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state, w_state_nx;

    logic              r_sa, r_sb;
    logic [B_W-1:0]    r_bmag;
    logic [NW-1:0]     r_num;
    logic [NW-1:0]     r_quo;
    logic [B_W:0]      r_rem;
    logic [CW-1:0]     r_cnt;

    logic              r_busy, r_done, r_ovf, r_div_zero;
    logic [Q_W-1:0]    r_q;
    logic [B_W:0]      r_r;

    logic [A_W-1:0]    w_a_mag;
    logic [B_W-1:0]    w_b_mag;
    logic [B_W:0]      w_rem_sh;
    logic              w_ge;
    logic [B_W:0]      w_rem_nx;
    logic              w_sq;
    logic [Q_W-1:0]    w_q_fix;
    logic              w_ovf_fix;
    logic [B_W:0]      w_r_fix;
    logic              w_bzero;

    // Unsigned magnitudes keep the most negative input exact.
    assign w_a_mag = a[A_W-1] ? -a : a;
    assign w_b_mag = b[B_W-1] ? -b : b;

    // Partial remainder stays below |b| <= 2^(B_W-1), so its top bit is always 0 before the shift.
    assign w_rem_sh = {r_rem[B_W-1:0], r_num[NW-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_bmag});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_bmag}) : w_rem_sh;

    assign w_sq    = r_sa ^ r_sb;
    assign w_bzero = (r_bmag == '0);

    always_comb begin
        w_q_fix   = '0;
        w_ovf_fix = 1'b0;
        if (w_bzero) begin
            w_ovf_fix = 1'b1;
            w_q_fix   = r_sa ? C_Q_MIN : C_Q_MAX;
        end else if (w_sq) begin
            if (r_quo > C_NEG_MAG) begin
                w_ovf_fix = 1'b1;
                w_q_fix   = C_Q_MIN;
            end else begin
                w_q_fix   = Q_W'(-r_quo);
            end
        end else begin
            if (r_quo > C_POS_LIM) begin
                w_ovf_fix = 1'b1;
                w_q_fix   = C_Q_MAX;
            end else begin
                w_q_fix   = Q_W'(r_quo);
            end
        end
    end

    assign w_r_fix = w_bzero ? '0 : (r_sa ? -r_rem : r_rem);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start_sig)     w_state_nx = S_CALC;
            S_CALC:  if (r_cnt == '0)   w_state_nx = S_FIX;
            S_FIX:                      w_state_nx = S_IDLE;
            default:                    w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_bmag     <= '0;
            r_num      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_div_zero <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_sig) begin
                        r_sa   <= a[A_W-1];
                        r_sb   <= b[B_W-1];
                        r_bmag <= w_b_mag;
                        r_num  <= {w_a_mag, {FRAC_W{1'b0}}};
                        r_quo  <= '0;
                        r_rem  <= '0;
                        r_cnt  <= CW'(NW - 1);
                        r_busy <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_num <= {r_num[NW-2:0], 1'b0};
                    r_quo <= {r_quo[NW-2:0], w_ge};
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_q        <= w_q_fix;
                    r_r        <= w_r_fix;
                    r_ovf      <= w_ovf_fix;
                    r_div_zero <= w_bzero;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done_sig = r_done;
    assign q        = r_q;
    assign r        = r_r;
    assign ovf      = r_ovf;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire
